// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Multi-lane control-flow resolve stage. Up to NR_LANES branch/jump
// instructions are resolved per cycle, and every result appears one cycle
// later on registered outputs. Lane 0 is the oldest lane. The oldest lane that
// mispredicts or faults kills all younger lanes in its group. Resolved
// BRANCH/JALR outcomes are queued for the frontend predictor. Two saturating
// counters track resolved instructions and mispredictions.
//
// Optional build macro: BRU_RVC_EN. When it is defined, compressed targets
// (target[1]==1) are legal and ex_valid_o is never raised.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              drop this cycle's group, clear stage-1 valids and
//                        the update FIFO (counters and overflow are kept)
//   valid_i/ready_o      lane-group input; ready_o is registered
//   op_i, pc_i, base_i, imm_i, cmp_res_i, pred_cf_i, pred_addr_i,
//   trans_id_i           per-lane operands, packed lane 0 in the LSBs
//   wb_*                 per-lane writeback (link value pc+4)
//   ex_valid_o/ex_tval_o per-lane misaligned-target exception
//   mispredict_o/redirect_pc_o  one-cycle redirect for the oldest mispredict
//   upd_*                head of the predictor-update FIFO
//   branch_cnt_o, mispred_cnt_o  saturating performance counters
//   overflow_o           sticky: a group arrived while ready_o was low
//
// Handshakes: a lane group is taken when any valid_i bit is high and ready_o
// is high. A group offered while ready_o is low is dropped. The FIFO head
// moves on when upd_valid_o && upd_ready_i. upd_valid_o never depends on
// upd_ready_i.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int NR_LANES   = 2,
  parameter int VLEN       = 64,
  parameter int TRANS_ID_W = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NR_LANES-1:0]            valid_i,
  output logic                           ready_o,
  input  logic [2*NR_LANES-1:0]          op_i,
  input  logic [VLEN*NR_LANES-1:0]       pc_i,
  input  logic [VLEN*NR_LANES-1:0]       base_i,
  input  logic [VLEN*NR_LANES-1:0]       imm_i,
  input  logic [NR_LANES-1:0]            cmp_res_i,
  input  logic [2*NR_LANES-1:0]          pred_cf_i,
  input  logic [VLEN*NR_LANES-1:0]       pred_addr_i,
  input  logic [TRANS_ID_W*NR_LANES-1:0] trans_id_i,
  output logic [NR_LANES-1:0]            wb_valid_o,
  output logic [TRANS_ID_W*NR_LANES-1:0] wb_trans_id_o,
  output logic [VLEN*NR_LANES-1:0]       wb_rd_o,
  output logic [NR_LANES-1:0]            ex_valid_o,
  output logic [VLEN*NR_LANES-1:0]       ex_tval_o,
  output logic                           mispredict_o,
  output logic [VLEN-1:0]                redirect_pc_o,
  output logic                           upd_valid_o,
  input  logic                           upd_ready_i,
  output logic [VLEN-1:0]                upd_pc_o,
  output logic [VLEN-1:0]                upd_target_o,
  output logic                           upd_taken_o,
  output logic                           upd_mispredict_o,
  output logic [1:0]                     upd_cf_o,
  output logic [CNT_W-1:0]               branch_cnt_o,
  output logic [CNT_W-1:0]               mispred_cnt_o,
  output logic                           overflow_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNTF_W = PTR_W + 1;
  localparam int LCNT_W = $clog2(NR_LANES + 1);

  localparam logic [1:0] OP_BRANCH = 2'd0;
  localparam logic [1:0] OP_JALR   = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  localparam logic [1:0] CF_NONE   = 2'd0;
  localparam logic [1:0] CF_BRANCH = 2'd1;
  localparam logic [1:0] CF_JUMP   = 2'd2;
  localparam logic [1:0] CF_RETURN = 2'd3;

  // ---------------------------------------------------------------------------
  // Stage 0: per-lane resolve, kill chain, enqueue slot assignment
  // ---------------------------------------------------------------------------
  logic [VLEN-1:0]     next_pc  [NR_LANES];
  logic [VLEN-1:0]     tgt      [NR_LANES];
  logic [VLEN-1:0]     resolved [NR_LANES];
  logic [1:0]          upd_cf   [NR_LANES];
  logic [PTR_W-1:0]    enq_off  [NR_LANES];
  logic [NR_LANES-1:0] taken, exc, mis, surv, enq;
  logic [CNTF_W-1:0]   n_enq;
  logic [LCNT_W-1:0]   n_surv;
  logic                mis_any;
  logic [VLEN-1:0]     redir;
  logic                accept;

  // flush_i beats valid_i, and a group can only be taken when ready_o is high.
  assign accept = !flush_i && ready_o;

  always_comb begin : p_stage0
    logic            blocked;
    logic            mis_raw;
    logic [1:0]      op_l;
    logic [1:0]      pcf_l;
    logic [VLEN-1:0] sum_l;
    blocked = 1'b0;
    mis_raw = 1'b0;
    op_l    = '0;
    pcf_l   = '0;
    sum_l   = '0;
    n_enq   = '0;
    n_surv  = '0;
    mis_any = 1'b0;
    redir   = '0;
    for (int l = 0; l < NR_LANES; l++) begin
      op_l        = op_i[2*l +: 2];
      pcf_l       = pred_cf_i[2*l +: 2];
      next_pc[l]  = pc_i[VLEN*l +: VLEN] + VLEN'(4);
      sum_l       = base_i[VLEN*l +: VLEN] + imm_i[VLEN*l +: VLEN];
      if (op_l == OP_JALR) sum_l[0] = 1'b0;
      tgt[l]      = sum_l;
      taken[l]    = (op_l == OP_BRANCH) ? cmp_res_i[l] : 1'b1;
      resolved[l] = taken[l] ? tgt[l] : next_pc[l];
`ifdef BRU_RVC_EN
      exc[l]      = 1'b0;
`else
      exc[l]      = taken[l] & tgt[l][1];
`endif
      case (op_l)
        OP_BRANCH: mis_raw = taken[l] != (pcf_l == CF_BRANCH);
        OP_JALR:   mis_raw = (pcf_l == CF_NONE) ||
                             (tgt[l] != pred_addr_i[VLEN*l +: VLEN]);
        default:   mis_raw = 1'b0;
      endcase
      // A faulting lane traps instead of redirecting.
      mis[l]  = mis_raw & ~exc[l];
      surv[l] = accept && valid_i[l] && (op_l != OP_RSVD) && !blocked;
      // Only the first surviving mispredict can get here, because it blocks the rest.
      if (surv[l] && mis[l]) begin
        mis_any = 1'b1;
        redir   = resolved[l];
      end
      if (surv[l] && (mis[l] || exc[l])) blocked = 1'b1;
      enq[l]     = surv[l] && ((op_l == OP_BRANCH) || (op_l == OP_JALR));
      enq_off[l] = n_enq[PTR_W-1:0];
      if (enq[l])  n_enq  = n_enq + CNTF_W'(1);
      if (surv[l]) n_surv = n_surv + LCNT_W'(1);
      if (op_l == OP_BRANCH)       upd_cf[l] = CF_BRANCH;
      else if (pcf_l == CF_RETURN) upd_cf[l] = CF_RETURN;
      else                         upd_cf[l] = CF_JUMP;
    end
  end

  // ---------------------------------------------------------------------------
  // Predictor-update FIFO
  // ---------------------------------------------------------------------------
  logic [VLEN-1:0]       f_pc  [FIFO_DEPTH];
  logic [VLEN-1:0]       f_tgt [FIFO_DEPTH];
  logic [1:0]            f_cf  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_taken, f_mis;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNTF_W-1:0]     count, count_nxt;
  logic                  deq, ready_nxt;

  assign upd_valid_o = (count != '0);
  assign deq         = upd_valid_o && upd_ready_i && !flush_i;
  assign count_nxt   = count + n_enq - CNTF_W'(deq);
  // The next cycle must have room for a full lane group.
  assign ready_nxt   = (count_nxt <= CNTF_W'(FIFO_DEPTH - NR_LANES));

  // The head is masked when the FIFO is empty so that storage which was never written cannot show on the port.
  assign upd_pc_o         = upd_valid_o ? f_pc[rd_ptr]    : '0;
  assign upd_target_o     = upd_valid_o ? f_tgt[rd_ptr]   : '0;
  assign upd_taken_o      = upd_valid_o ? f_taken[rd_ptr] : 1'b0;
  assign upd_mispredict_o = upd_valid_o ? f_mis[rd_ptr]   : 1'b0;
  assign upd_cf_o         = upd_valid_o ? f_cf[rd_ptr]    : 2'd0;

  // Storage without reset. Surviving lanes are written in lane order, starting at wr_ptr.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NR_LANES; l++) begin
      if (enq[l]) begin
        f_pc[wr_ptr + enq_off[l]]    <= pc_i[VLEN*l +: VLEN];
        f_tgt[wr_ptr + enq_off[l]]   <= resolved[l];
        f_taken[wr_ptr + enq_off[l]] <= taken[l];
        f_mis[wr_ptr + enq_off[l]]   <= mis[l];
        f_cf[wr_ptr + enq_off[l]]    <= upd_cf[l];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers, FIFO control, counters
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] bsum, msum;
  assign bsum = {1'b0, branch_cnt_o}  + (CNT_W+1)'(n_surv);
  assign msum = {1'b0, mispred_cnt_o} + (CNT_W+1)'(mis_any);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o    <= '0;
      wb_trans_id_o <= '0;
      wb_rd_o       <= '0;
      ex_valid_o    <= '0;
      ex_tval_o     <= '0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ready_o       <= 1'b1;
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
      overflow_o    <= 1'b0;
    end else begin
      for (int l = 0; l < NR_LANES; l++) begin
        wb_trans_id_o[TRANS_ID_W*l +: TRANS_ID_W] <= trans_id_i[TRANS_ID_W*l +: TRANS_ID_W];
        wb_rd_o[VLEN*l +: VLEN]                   <= next_pc[l];
        ex_tval_o[VLEN*l +: VLEN]                 <= tgt[l];
      end
      if (flush_i) begin
        wb_valid_o   <= '0;
        ex_valid_o   <= '0;
        mispredict_o <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        ready_o      <= 1'b1;
      end else begin
        wb_valid_o    <= surv;
        ex_valid_o    <= surv & exc;
        mispredict_o  <= mis_any;
        redirect_pc_o <= redir;
        wr_ptr        <= wr_ptr + n_enq[PTR_W-1:0];
        rd_ptr        <= rd_ptr + PTR_W'(deq);
        count         <= count_nxt;
        ready_o       <= ready_nxt;
      end
      // surv and mis_any are already zero during a flush.
      branch_cnt_o  <= bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
      mispred_cnt_o <= msum[CNT_W] ? '1 : msum[CNT_W-1:0];
      if (!flush_i && !ready_o && (|valid_i)) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// Directed bench for branch_resolve_unit with the default parameters
// (2 lanes, VLEN 64, FIFO depth 4).
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam logic [1:0] OP_BR = 2'd0, OP_JAL = 2'd1, OP_JALR = 2'd2;
  localparam logic [1:0] CF_NONE = 2'd0, CF_BR = 2'd1, CF_JUMP = 2'd2, CF_RET = 2'd3;

  logic          clk, rst_i, flush_i;
  logic [1:0]    valid_i;
  logic          ready_o;
  logic [3:0]    op_i;
  logic [127:0]  pc_i, base_i, imm_i, pred_addr_i;
  logic [1:0]    cmp_res_i;
  logic [3:0]    pred_cf_i;
  logic [5:0]    trans_id_i;
  logic [1:0]    wb_valid_o;
  logic [5:0]    wb_trans_id_o;
  logic [127:0]  wb_rd_o;
  logic [1:0]    ex_valid_o;
  logic [127:0]  ex_tval_o;
  logic          mispredict_o;
  logic [63:0]   redirect_pc_o;
  logic          upd_valid_o, upd_ready_i;
  logic [63:0]   upd_pc_o, upd_target_o;
  logic          upd_taken_o, upd_mispredict_o;
  logic [1:0]    upd_cf_o;
  logic [31:0]   branch_cnt_o, mispred_cnt_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_bcnt = 0;
  logic [31:0] exp_mcnt = 0;
  logic [1:0]  exp_ex;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;
  logic [2:0]  tid_a, tid_b;

  branch_resolve_unit dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .pc_i(pc_i), .base_i(base_i), .imm_i(imm_i),
    .cmp_res_i(cmp_res_i), .pred_cf_i(pred_cf_i), .pred_addr_i(pred_addr_i),
    .trans_id_i(trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_rd_o(wb_rd_o),
    .ex_valid_o(ex_valid_o), .ex_tval_o(ex_tval_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
    .upd_taken_o(upd_taken_o), .upd_mispredict_o(upd_mispredict_o),
    .upd_cf_o(upd_cf_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o),
    .overflow_o(overflow_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i     = '0;
    op_i        = '0;
    pc_i        = '0;
    base_i      = '0;
    imm_i       = '0;
    cmp_res_i   = '0;
    pred_cf_i   = '0;
    pred_addr_i = '0;
    trans_id_i  = '0;
  endtask

  task automatic set_lane(input int l, input logic [1:0] op, input logic [63:0] pc,
                          input logic [63:0] base, input logic [63:0] imm, input logic cmp,
                          input logic [1:0] pcf, input logic [63:0] paddr, input logic [2:0] tid);
    valid_i[l]             = 1'b1;
    op_i[2*l +: 2]         = op;
    pc_i[64*l +: 64]       = pc;
    base_i[64*l +: 64]     = base;
    imm_i[64*l +: 64]      = imm;
    cmp_res_i[l]           = cmp;
    pred_cf_i[2*l +: 2]    = pcf;
    pred_addr_i[64*l +: 64] = paddr;
    trans_id_i[3*l +: 3]   = tid;
  endtask

  task automatic drain_one();
    upd_ready_i = 1'b1;
    cycle();
    upd_ready_i = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; upd_ready_i = 1'b0;
    clear_inputs();
    cycle(); cycle();
    rst_i = 1'b0;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
    n_checks++; if (upd_valid_o !== 1'b0) $display("FAIL reset_upd_valid: got %b want 0", upd_valid_o); else n_pass++;
    n_checks++; if (wb_valid_o !== 2'b00) $display("FAIL reset_wb_valid: got %b want 00", wb_valid_o); else n_pass++;
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL reset_mispredict: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (branch_cnt_o !== 32'd0) $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_o); else n_pass++;
  endtask

  task automatic test_branch_mispredict();
    clear_inputs();
    set_lane(0, OP_BR, 64'h1000, 64'h1000, 64'h40, 1'b1, CF_NONE, 64'h0, 3'd5);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
    n_checks++; if (mispredict_o !== 1'b1) $display("FAIL br_mispredict: got %b want 1", mispredict_o); else n_pass++;
    n_checks++; if (redirect_pc_o !== 64'h1040) $display("FAIL br_redirect: got %0h want 1040", redirect_pc_o); else n_pass++;
    n_checks++; if (wb_valid_o !== 2'b01) $display("FAIL br_wb_valid: got %b want 01", wb_valid_o); else n_pass++;
    n_checks++; if (wb_trans_id_o[2:0] !== 3'd5) $display("FAIL br_trans_id: got %0d want 5", wb_trans_id_o[2:0]); else n_pass++;
    n_checks++; if (upd_valid_o !== 1'b1) $display("FAIL br_upd_valid: got %b want 1", upd_valid_o); else n_pass++;
    n_checks++; if (upd_pc_o !== 64'h1000) $display("FAIL br_upd_pc: got %0h want 1000", upd_pc_o); else n_pass++;
    n_checks++; if (upd_target_o !== 64'h1040) $display("FAIL br_upd_target: got %0h want 1040", upd_target_o); else n_pass++;
    n_checks++; if ({upd_taken_o, upd_mispredict_o, upd_cf_o} !== 4'b1101)
      $display("FAIL br_upd_flags: got %b want 1101", {upd_taken_o, upd_mispredict_o, upd_cf_o}); else n_pass++;
    n_checks++; if (branch_cnt_o !== exp_bcnt) $display("FAIL br_branch_cnt: got %0d want %0d", branch_cnt_o, exp_bcnt); else n_pass++;
    n_checks++; if (mispred_cnt_o !== exp_mcnt) $display("FAIL br_mispred_cnt: got %0d want %0d", mispred_cnt_o, exp_mcnt); else n_pass++;
    drain_one();
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL br_pulse_end: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (upd_valid_o !== 1'b0) $display("FAIL br_drained: got %b want 0", upd_valid_o); else n_pass++;
  endtask

  task automatic test_jalr();
`ifdef BRU_RVC_EN
    exp_ex = 2'b00;
`else
    exp_ex = 2'b01;
`endif
    // Target 0x2003 with bit 0 cleared is 0x2002, which matches the prediction.
    clear_inputs();
    set_lane(0, OP_JALR, 64'h2000, 64'h2003, 64'h0, 1'b0, CF_JUMP, 64'h2002, 3'd2);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 1;
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL jalr_mispredict: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (wb_rd_o[63:0] !== 64'h2004) $display("FAIL jalr_wb_rd: got %0h want 2004", wb_rd_o[63:0]); else n_pass++;
    n_checks++; if (wb_valid_o !== 2'b01) $display("FAIL jalr_wb_valid: got %b want 01", wb_valid_o); else n_pass++;
    n_checks++; if (upd_cf_o !== 2'd2) $display("FAIL jalr_upd_cf: got %0d want 2", upd_cf_o); else n_pass++;
    n_checks++; if (upd_mispredict_o !== 1'b0) $display("FAIL jalr_upd_mis: got %b want 0", upd_mispredict_o); else n_pass++;
    n_checks++; if (ex_valid_o !== exp_ex) $display("FAIL jalr_ex_valid: got %b want %b", ex_valid_o, exp_ex); else n_pass++;
    drain_one();
    // A return whose target 0x2005+3=0x2008 differs from the prediction.
    set_lane(0, OP_JALR, 64'h2100, 64'h2005, 64'h3, 1'b0, CF_RET, 64'h2000, 3'd3);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
    n_checks++; if (mispredict_o !== 1'b1) $display("FAIL ret_mispredict: got %b want 1", mispredict_o); else n_pass++;
    n_checks++; if (redirect_pc_o !== 64'h2008) $display("FAIL ret_redirect: got %0h want 2008", redirect_pc_o); else n_pass++;
    n_checks++; if (upd_cf_o !== 2'd3) $display("FAIL ret_upd_cf: got %0d want 3", upd_cf_o); else n_pass++;
    n_checks++; if (upd_target_o !== 64'h2008) $display("FAIL ret_upd_target: got %0h want 2008", upd_target_o); else n_pass++;
    n_checks++; if (mispred_cnt_o !== exp_mcnt) $display("FAIL ret_mispred_cnt: got %0d want %0d", mispred_cnt_o, exp_mcnt); else n_pass++;
    drain_one();
  endtask

  task automatic test_kill();
    // Lane 0 was predicted taken but is not taken, so it redirects to pc+4 and kills lane 1.
    clear_inputs();
    set_lane(0, OP_BR,  64'h4000, 64'h4000, 64'h10, 1'b0, CF_BR,   64'h4010, 3'd1);
    set_lane(1, OP_JAL, 64'h4004, 64'h4004, 64'h20, 1'b0, CF_JUMP, 64'h4024, 3'd2);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
    n_checks++; if (wb_valid_o !== 2'b01) $display("FAIL kill_wb_valid: got %b want 01", wb_valid_o); else n_pass++;
    n_checks++; if (redirect_pc_o !== 64'h4004) $display("FAIL kill_redirect: got %0h want 4004", redirect_pc_o); else n_pass++;
    n_checks++; if (branch_cnt_o !== exp_bcnt) $display("FAIL kill_branch_cnt: got %0d want %0d", branch_cnt_o, exp_bcnt); else n_pass++;
    n_checks++; if (upd_pc_o !== 64'h4000) $display("FAIL kill_upd_pc: got %0h want 4000", upd_pc_o); else n_pass++;
    drain_one();
    // No kill: a correct JAL followed by a not-taken branch.
    tid_a = 3'($urandom_range(0, 7));
    tid_b = 3'($urandom_range(0, 7));
    set_lane(0, OP_JAL, 64'h5000, 64'h5000, 64'h100, 1'b0, CF_JUMP, 64'h5100, tid_a);
    set_lane(1, OP_BR,  64'h5004, 64'h5004, 64'h8,   1'b0, CF_NONE, 64'h0,    tid_b);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 2;
    n_checks++; if (wb_valid_o !== 2'b11) $display("FAIL pair_wb_valid: got %b want 11", wb_valid_o); else n_pass++;
    n_checks++; if (wb_trans_id_o !== {tid_b, tid_a}) $display("FAIL pair_trans_id: got %0h want %0h", wb_trans_id_o, {tid_b, tid_a}); else n_pass++;
    n_checks++; if (wb_rd_o[127:64] !== 64'h5008) $display("FAIL pair_wb_rd1: got %0h want 5008", wb_rd_o[127:64]); else n_pass++;
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL pair_mispredict: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (branch_cnt_o !== exp_bcnt) $display("FAIL pair_branch_cnt: got %0d want %0d", branch_cnt_o, exp_bcnt); else n_pass++;
    n_checks++; if ({upd_valid_o, upd_taken_o} !== 2'b10) $display("FAIL pair_upd_head: got %b want 10", {upd_valid_o, upd_taken_o}); else n_pass++;
    n_checks++; if (upd_pc_o !== 64'h5004) $display("FAIL pair_upd_pc: got %0h want 5004", upd_pc_o); else n_pass++;
    drain_one();
  endtask

  task automatic test_misaligned();
`ifdef BRU_RVC_EN
    exp_ex = 2'b00;
`else
    exp_ex = 2'b01;
`endif
    clear_inputs();
    set_lane(0, OP_JAL, 64'h3000, 64'h3000, 64'h2, 1'b0, CF_JUMP, 64'h3002, 3'd4);
    cycle();
    clear_inputs();
    exp_bcnt = exp_bcnt + 1;
    n_checks++; if (ex_valid_o !== exp_ex) $display("FAIL mis_ex_valid: got %b want %b", ex_valid_o, exp_ex); else n_pass++;
    n_checks++; if (ex_tval_o[63:0] !== 64'h3002) $display("FAIL mis_ex_tval: got %0h want 3002", ex_tval_o[63:0]); else n_pass++;
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL mis_mispredict: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (upd_valid_o !== 1'b0) $display("FAIL mis_no_enqueue: got %b want 0", upd_valid_o); else n_pass++;
  endtask

  task automatic test_overflow();
    upd_ready_i = 1'b0;
    clear_inputs();
    set_lane(0, OP_BR, 64'h6000, 64'h6000, 64'h100, 1'b0, CF_NONE, 64'h0, 3'd0);
    set_lane(1, OP_BR, 64'h6004, 64'h6004, 64'h100, 1'b0, CF_NONE, 64'h0, 3'd1);
    exp_q.push_back(64'h6000); exp_q.push_back(64'h6004);
    cycle();
    n_checks++; if (ready_o !== 1'b1) $display("FAIL ovf_ready_half: got %b want 1", ready_o); else n_pass++;
    clear_inputs();
    set_lane(0, OP_BR, 64'h6008, 64'h6008, 64'h100, 1'b0, CF_NONE, 64'h0, 3'd2);
    set_lane(1, OP_BR, 64'h600c, 64'h600c, 64'h100, 1'b0, CF_NONE, 64'h0, 3'd3);
    exp_q.push_back(64'h6008); exp_q.push_back(64'h600c);
    cycle();
    exp_bcnt = exp_bcnt + 4;
    n_checks++; if (ready_o !== 1'b0) $display("FAIL ovf_ready_full: got %b want 0", ready_o); else n_pass++;
    clear_inputs();
    set_lane(0, OP_BR, 64'h7000, 64'h7000, 64'h100, 1'b1, CF_NONE, 64'h0, 3'd4);
    set_lane(1, OP_BR, 64'h7004, 64'h7004, 64'h100, 1'b0, CF_NONE, 64'h0, 3'd5);
    cycle();
    clear_inputs();
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else n_pass++;
    n_checks++; if (wb_valid_o !== 2'b00) $display("FAIL ovf_dropped_wb: got %b want 00", wb_valid_o); else n_pass++;
    n_checks++; if (branch_cnt_o !== exp_bcnt) $display("FAIL ovf_branch_cnt: got %0d want %0d", branch_cnt_o, exp_bcnt); else n_pass++;
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL ovf_dropped_mis: got %b want 0", mispredict_o); else n_pass++;
    upd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_q.pop_front();
      n_checks++; if (upd_valid_o !== 1'b1) $display("FAIL ovf_drain_valid%0d: got %b want 1", i, upd_valid_o); else n_pass++;
      n_checks++; if (upd_pc_o !== exp_pc) $display("FAIL ovf_drain_pc%0d: got %0h want %0h", i, upd_pc_o, exp_pc); else n_pass++;
      cycle();
    end
    upd_ready_i = 1'b0;
    n_checks++; if (upd_valid_o !== 1'b0) $display("FAIL ovf_drain_empty: got %b want 0", upd_valid_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL ovf_ready_back: got %b want 1", ready_o); else n_pass++;
  endtask

  task automatic test_flush();
    upd_ready_i = 1'b0;
    clear_inputs();
    set_lane(0, OP_BR, 64'h8000, 64'h8000, 64'h40, 1'b0, CF_NONE, 64'h0, 3'd0);
    set_lane(1, OP_BR, 64'h8004, 64'h8004, 64'h40, 1'b0, CF_NONE, 64'h0, 3'd1);
    cycle();
    clear_inputs();
    set_lane(0, OP_BR, 64'h8008, 64'h8008, 64'h40, 1'b0, CF_NONE, 64'h0, 3'd2);
    cycle();
    exp_bcnt = exp_bcnt + 3;
    n_checks++; if ({upd_valid_o, ready_o} !== 2'b10) $display("FAIL flush_pre_state: got %b want 10", {upd_valid_o, ready_o}); else n_pass++;
    clear_inputs();
    set_lane(0, OP_BR, 64'h9000, 64'h9000, 64'h40, 1'b1, CF_NONE, 64'h0, 3'd3);
    flush_i = 1'b1;
    upd_ready_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    upd_ready_i = 1'b0;
    clear_inputs();
    n_checks++; if (mispredict_o !== 1'b0) $display("FAIL flush_mispredict: got %b want 0", mispredict_o); else n_pass++;
    n_checks++; if (upd_valid_o !== 1'b0) $display("FAIL flush_upd_valid: got %b want 0", upd_valid_o); else n_pass++;
    n_checks++; if (wb_valid_o !== 2'b00) $display("FAIL flush_wb_valid: got %b want 00", wb_valid_o); else n_pass++;
    n_checks++; if (branch_cnt_o !== exp_bcnt) $display("FAIL flush_branch_cnt: got %0d want %0d", branch_cnt_o, exp_bcnt); else n_pass++;
    n_checks++; if (mispred_cnt_o !== exp_mcnt) $display("FAIL flush_mispred_cnt: got %0d want %0d", mispred_cnt_o, exp_mcnt); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", ready_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL flush_keeps_overflow: got %b want 1", overflow_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_lane(0, OP_BR, 64'hA000, 64'hA000, 64'h80, 1'b1, CF_NONE, 64'h0, 3'd6);
    cycle();
    exp_bcnt = exp_bcnt + 1; exp_mcnt = exp_mcnt + 1;
    n_checks++; if (mispred_cnt_o !== exp_mcnt) $display("FAIL mid_mispred_cnt: got %0d want %0d", mispred_cnt_o, exp_mcnt); else n_pass++;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    clear_inputs();
    n_checks++; if ({branch_cnt_o, mispred_cnt_o} !== 64'd0) $display("FAIL mid_counters: got %0h want 0", {branch_cnt_o, mispred_cnt_o}); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL mid_overflow: got %b want 0", overflow_o); else n_pass++;
    n_checks++; if ({upd_valid_o, mispredict_o, wb_valid_o} !== 4'b0000)
      $display("FAIL mid_valids: got %b want 0000", {upd_valid_o, mispredict_o, wb_valid_o}); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL mid_ready: got %b want 1", ready_o); else n_pass++;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_branch_mispredict();
    test_jalr();
    test_kill();
    test_misaligned();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised multi-lane successor to the single-lane branch unit. Resolves up to NR_LANES control-flow instructions per cycle with one cycle of latency.
- Selects the oldest misprediction and kills younger lanes in the same cycle.
- Buffers resolved-branch updates for the frontend predictor in a ready/valid FIFO and keeps saturating performance counters.
- Sits in the execute stage, between issue and the frontend BTB/BHT update path.

Parameters:
- NR_LANES, 2, parallel resolve lanes; lane 0 is the oldest.
- VLEN, 64, virtual address width.
- TRANS_ID_W, 3, scoreboard transaction ID width.
- FIFO_DEPTH, 4, resolved-update FIFO entries; power of two, must be >= NR_LANES.
- CNT_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush.
- valid_i  in  NR_LANES  lane valid.
- ready_o  out  1  unit can accept a full lane group.
- op_i  in  2*NR_LANES  per lane: 0 BRANCH, 1 JAL, 2 JALR, 3 reserved (treated as not valid).
- pc_i  in  VLEN*NR_LANES  instruction PC.
- base_i  in  VLEN*NR_LANES  jump base: PC for BRANCH/JAL, rs1 for JALR.
- imm_i  in  VLEN*NR_LANES  sign-extended immediate.
- cmp_res_i  in  NR_LANES  ALU compare result; 1 means taken.
- pred_cf_i  in  2*NR_LANES  predicted cf: 0 NoCF, 1 Branch, 2 Jump, 3 Return.
- pred_addr_i  in  VLEN*NR_LANES  predicted target.
- trans_id_i  in  TRANS_ID_W*NR_LANES  transaction ID.
- wb_valid_o  out  NR_LANES  result valid.
- wb_trans_id_o  out  TRANS_ID_W*NR_LANES  result transaction ID.
- wb_rd_o  out  VLEN*NR_LANES  link value, pc+4.
- ex_valid_o  out  NR_LANES  instruction-address-misaligned exception.
- ex_tval_o  out  VLEN*NR_LANES  faulting target.
- mispredict_o  out  1  one-cycle redirect pulse.
- redirect_pc_o  out  VLEN  correct next PC for the oldest mispredict.
- upd_valid_o  out  1  FIFO head valid.
- upd_ready_i  in  1  frontend accepts the FIFO head.
- upd_pc_o  out  VLEN  head entry PC.
- upd_target_o  out  VLEN  head entry resolved target.
- upd_taken_o  out  1  head entry taken.
- upd_mispredict_o  out  1  head entry mispredicted.
- upd_cf_o  out  2  head entry cf type: 1 Branch, 2 JumpR, 3 Return.
- branch_cnt_o  out  CNT_W  resolved instructions.
- mispred_cnt_o  out  CNT_W  mispredictions.
- overflow_o  out  1  sticky flag: lane input arrived while ready_o was low.

Behaviour:
- Reset: every output register, FIFO pointers/count, counters and overflow_o go to 0. ready_o = 1 after reset.
- Stage 0, combinational per lane:
  - next = pc+4.
  - target = base+imm, modulo 2^VLEN; bit0 forced to 0 for JALR.
  - taken = cmp_res for BRANCH; 1 for JAL/JALR.
  - resolved = taken ? target : next.
- Misprediction, per lane:
  - BRANCH: taken != (pred_cf==Branch).
  - JALR: pred_cf==NoCF or target != pred_addr.
  - JAL: never mispredicts.
- Misalignment: taken and target[1]==1 raises an exception. The exception suppresses mispredict for that lane; the lane still writes back.
- Kill: the lowest-index lane with a mispredict or exception kills every higher-index lane. Killed lanes produce no writeback, no FIFO entry and no counter increment.
- Stage 1: all outputs are registered, so latency is exactly 1 cycle.
  - mispredict_o = 1 with redirect_pc_o = resolved of the oldest mispredicting lane.
- Update cf encoding: BRANCH→1. JALR→3 if pred_cf==Return, otherwise 2. JAL→2.
- FIFO enqueue: surviving lanes with op BRANCH or JALR enqueue in lane order in the same cycle they are sampled.
- FIFO dequeue: occurs when upd_valid_o && upd_ready_i. Enqueue and dequeue in the same cycle are both honoured.
- ready_o is registered and equals (free slots after this cycle >= NR_LANES).
  - If any valid_i is asserted while ready_o==0, that whole group is dropped and overflow_o is set. overflow_o clears only on rst_i.
- flush_i:
  - Clears the stage-1 valids and mispredict_o next cycle.
  - Empties the FIFO.
  - Discards that cycle's inputs.
  - Counters and overflow_o are kept.
  - flush_i has priority over valid_i and over upd_ready_i.
- Counters: branch_cnt_o adds the number of surviving lanes each cycle; mispred_cnt_o adds 1 per mispredict pulse. Both saturate at all-ones with no wrap.
- Reset asserted mid-operation behaves like flush_i plus counter and overflow_o clear.

Optional Feature:
- Macro BRU_RVC_EN.
- Defined: compressed ISA is supported. The misalignment exception is removed, ex_valid_o is tied to 0, and target[1]==1 is legal.
- Undefined: misalignment checking applies exactly as in Behaviour.

Test Plan:
- Lane0 BRANCH, pc=0x1000, base=0x1000, imm=0x40, cmp=1, pred_cf=NoCF → next cycle: mispredict_o=1, redirect_pc_o=0x1040. FIFO entry {0x1000, 0x1040, taken=1, mispred=1, cf=1}.
- Lane0 JALR, base=0x2003, imm=0x0, pred_cf=Jump, pred_addr=0x2002 → no mispredict, wb_rd_o=pc+4, FIFO cf=2.
- Two lanes, lane0 BRANCH mispredicts and lane1 JAL is valid → wb_valid_o=01, lane1 killed, branch_cnt_o increments by 1.
- Without BRU_RVC_EN: JAL with target 0x3002 → ex_valid_o[0]=1, ex_tval_o=0x3002, mispredict_o=0.
- Hold upd_ready_i=0 and send groups until ready_o=0 (FIFO_DEPTH=4, 2 lanes → ready_o low after 2 groups); send one more group → it is dropped and overflow_o=1. Then raise upd_ready_i → entries drain in order.
- flush_i asserted together with a mispredicting lane0 and 3 FIFO entries → mispredict_o stays 0, upd_valid_o=0 next cycle, counters unchanged.
